// File: rtl/axadd_error_monitor.sv
// ---------------------------------------------------------------------------
// axadd_error_monitor
//   Accuracy-characterisation stage for the approximate Ladner-Fischer adder.
//   Each accepted beat carries the operands and the adder's approximate sum.
//   The block recomputes the exact sum and forms the error distance
//   ED = |exact - approx|. Over a window of 2^WIN_LOG2 accepted beats it
//   accumulates:
//     - the count of erroneous beats (ED != 0),
//     - the saturating sum of ED,
//     - the maximum ED.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          pulse; opens a new window (only honoured in IDLE)
//   in_valid       beat valid
//   in_ready       beat accepted on in_valid & in_ready (high only in RUN)
//   op_a, op_b     adder operands (carry-in is 0)
//   approx_sum     approximate sum, MSB is the carry out
//   busy           window in progress (RUN or DRAIN)
//   done           one-cycle pulse when the window statistics are final
//   stat_valid     statistics hold a completed window
//   err_count      erroneous-beat count
//   sum_ed         saturating ED sum
//   max_ed         largest ED seen in the window
// ---------------------------------------------------------------------------

// Error distance of one beat: |(op_a + op_b) - approx_sum|, all unsigned.
module axadd_ed_calc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   approx_sum,
  output logic [WIDTH:0]   ed
);

  logic [WIDTH:0] exact;

  // Zero-extend before adding so the carry lands in the MSB.
  assign exact = {1'b0, op_a} + {1'b0, op_b};

  // The approximate adder may over- or under-estimate; take the magnitude.
  always_comb begin
    ed = '0;
    if (exact >= approx_sum) ed = exact - approx_sum;
    else                     ed = approx_sum - exact;
  end

endmodule

module axadd_error_monitor #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 8,
  parameter int ACC_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic [WIDTH:0]      approx_sum,
  output logic                busy,
  output logic                done,
  output logic                stat_valid,
  output logic [WIN_LOG2:0]   err_count,
  output logic [ACC_W-1:0]    sum_ed,
  output logic [WIDTH:0]      max_ed
);

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((1 << WIN_LOG2) - 1);

  // The ED sum is formed one bit wider than the larger of the accumulator
  // and ED so the overflow past 2^ACC_W-1 is visible before clamping.
  localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : (WIDTH + 1)) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   s;
  } beat_t;

  state_t state, state_n;

  logic [CNT_W-1:0] beat_cnt;
  logic             accept;
  logic             last_accept;
  logic             clr;

  beat_t            s1_beat;
  logic             s1_vld;

  logic [WIDTH:0]   ed;
  logic [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0] sum_nxt;

  // ------------------------------------------------------------------------
  // Handshake and status decode. All are decodes of the state register only,
  // so in_ready never depends combinationally on in_valid.
  // ------------------------------------------------------------------------
  assign in_ready    = (state == RUN);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (beat_cnt == LAST_BEAT);

  // A start in IDLE clears the window on the same edge it moves to RUN.
  assign clr         = (state == IDLE) && start;

  // ------------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start)       state_n = RUN;
      RUN:     if (last_accept) state_n = DRAIN;
      // One cycle lets the final beat retire from stage 2.
      DRAIN:                    state_n = DONE;
      DONE:                     state_n = IDLE;
      default:                  state_n = IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Beat counter and stat_valid
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      beat_cnt <= '0;
    else if (clr)    beat_cnt <= '0;
    else if (accept) beat_cnt <= beat_cnt + 1'b1;
  end

  // Raised on the DRAIN->DONE edge, when the last beat has just been
  // accumulated; held through IDLE until the next window opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               stat_valid <= 1'b0;
    else if (clr)             stat_valid <= 1'b0;
    else if (state == DRAIN)  stat_valid <= 1'b1;
  end

  // ------------------------------------------------------------------------
  // Stage 1: capture the accepted beat
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_beat <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_beat <= '{a: op_a, b: op_b, s: approx_sum};
    end
  end

  // ------------------------------------------------------------------------
  // Stage 2: error distance and accumulation
  // ------------------------------------------------------------------------
  axadd_ed_calc #(.WIDTH(WIDTH)) u_ed (
    .op_a       (s1_beat.a),
    .op_b       (s1_beat.b),
    .approx_sum (s1_beat.s),
    .ed         (ed)
  );

  // Clamp at all-ones. Once saturated, any further ED keeps it there.
  always_comb begin
    sum_ext = SUM_W'(sum_ed) + SUM_W'(ed);
    sum_nxt = sum_ed;
    if (sum_ext > SUM_W'(ACC_MAX)) sum_nxt = ACC_MAX;
    else                           sum_nxt = sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (clr) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (s1_vld) begin
      err_count <= err_count + CNT_W'(ed != '0);
      sum_ed    <= sum_nxt;
      if (ed > max_ed) max_ed <= ed;
    end
  end

endmodule

// File: tb/tb_axadd_error_monitor.sv
// Bench for axadd_error_monitor. Two instances share every input: one with a
// 32-bit ED accumulator and one with an 8-bit accumulator so saturation can be
// observed on the same traffic. Expected window results are pushed into a
// queue per instance before each window; monitors pop on done.
module tb_axadd_error_monitor;

  localparam int W  = 16;
  localparam int WL = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid;
  logic [W-1:0]  op_a, op_b;
  logic [W:0]    approx_sum;

  logic          in_ready, busy, done, stat_valid;
  logic [WL:0]   err_count;
  logic [31:0]   sum_ed;
  logic [W:0]    max_ed;

  logic          in_ready8, busy8, done8, stat_valid8;
  logic [WL:0]   err_count8;
  logic [7:0]    sum_ed8;
  logic [W:0]    max_ed8;

  always #5 clk = ~clk;

  axadd_error_monitor #(.WIDTH(W), .WIN_LOG2(WL), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum),
    .busy(busy), .done(done), .stat_valid(stat_valid),
    .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed)
  );

  axadd_error_monitor #(.WIDTH(W), .WIN_LOG2(WL), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready8), .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum),
    .busy(busy8), .done(done8), .stat_valid(stat_valid8),
    .err_count(err_count8), .sum_ed(sum_ed8), .max_ed(max_ed8)
  );

  typedef struct {
    logic [WL:0] err;
    logic [31:0] sum;
    logic [W:0]  mx;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ta[12];
  logic [W-1:0] tb[12];
  logic [W:0]   ts[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [WL:0] err, input logic [31:0] s32,
                      input logic [31:0] s8, input logic [W:0] mx);
    q32.push_back('{err: err, sum: s32, mx: mx});
    q8.push_back('{err: err, sum: s8, mx: mx});
  endtask

  // Drive one cycle of inputs at the falling edge.
  task automatic cyc(input logic st, input logic v, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W:0] s);
    @(negedge clk);
    start = st; in_valid = v; op_a = a; op_b = b; approx_sum = s;
  endtask

  // Back-to-back window from the vector table, with timing checks.
  task automatic run_win(input int base);
    cyc(1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, ta[base+i], tb[base+i], ts[base+i]);
      if (i == 0) chk("ready_after_start", in_ready, 1);
    end
    cyc(1'b0, 1'b0, '0, '0, '0);
    chk("drain_ready", in_ready, 0);
    chk("drain_done", done, 0);
    chk("drain_busy", busy, 1);
    chk("drain_stat_valid", stat_valid, 0);
    cyc(1'b0, 1'b0, '0, '0, '0);
    chk("done_pulse", done, 1);
    chk("done_ready", in_ready, 0);
    cyc(1'b0, 1'b0, '0, '0, '0);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_stat_valid", stat_valid, 1);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin : mon32
    if (rst_n && done) begin
      if (q32.size() == 0) chk("sb32_unexpected_done", q32.size(), 1);
      else begin
        e32 = q32.pop_front();
        chk("sb32_err_count", err_count, e32.err);
        chk("sb32_sum_ed", sum_ed, e32.sum);
        chk("sb32_max_ed", max_ed, e32.mx);
        chk("sb32_stat_valid", stat_valid, 1);
      end
    end
  end

  always @(negedge clk) begin : mon8
    if (rst_n && done8) begin
      if (q8.size() == 0) chk("sb8_unexpected_done", q8.size(), 1);
      else begin
        e8 = q8.pop_front();
        chk("sb8_err_count", err_count8, e8.err);
        chk("sb8_sum_ed", sum_ed8, e8.sum);
        chk("sb8_max_ed", max_ed8, e8.mx);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Window A: all exact
    ta[0] = 16'h0001; tb[0] = 16'h0002; ts[0] = 17'h00003;
    ta[1] = 16'h1234; tb[1] = 16'h1111; ts[1] = 17'h02345;
    ta[2] = 16'hFFFF; tb[2] = 16'h0001; ts[2] = 17'h10000;
    ta[3] = 16'h0000; tb[3] = 16'h0000; ts[3] = 17'h00000;
    // Window B: ED 2, 0x1FFFE, 0, 0
    ta[4] = 16'h00FF; tb[4] = 16'h0001; ts[4] = 17'h000FE;
    ta[5] = 16'hFFFF; tb[5] = 16'hFFFF; ts[5] = 17'h00000;
    ta[6] = 16'h00AA; tb[6] = 16'h0055; ts[6] = 17'h000FF;
    ta[7] = 16'h8000; tb[7] = 16'h8000; ts[7] = 17'h10000;
    // Window C: every ED = 0x80, both under- and over-estimates
    ta[8]  = 16'h0100; tb[8]  = 16'h0000; ts[8]  = 17'h00080;
    ta[9]  = 16'h0010; tb[9]  = 16'h0010; ts[9]  = 17'h000A0;
    ta[10] = 16'hFFFF; tb[10] = 16'h0001; ts[10] = 17'h0FF80;
    ta[11] = 16'h0000; tb[11] = 16'h0000; ts[11] = 17'h00080;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    op_a = '0; op_b = '0; approx_sum = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_sum_ed", sum_ed, 0);
    chk("rst_max_ed", max_ed, 0);

    // Partial window (ED 1 then 4), aborted by reset.
    cyc(1'b1, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b1, 16'h0001, 16'h0001, 17'h00003);
    cyc(1'b0, 1'b1, 16'h0002, 16'h0002, 17'h00000);
    cyc(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("part_err_count", err_count, 2);
    chk("part_sum_ed", sum_ed, 5);
    chk("part_max_ed", max_ed, 4);
    chk("part_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_err_count", err_count, 0);
    chk("async_sum_ed", sum_ed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_max_ed", max_ed, 0);
    chk("post_rst_stat_valid", stat_valid, 0);

    push(3'd0, 32'h0, 32'h0, 17'h0);
    run_win(0);
    push(3'd2, 32'h20000, 32'hFF, 17'h1FFFE);
    run_win(4);
    push(3'd4, 32'h200, 32'hFF, 17'h80);
    run_win(8);

    // Gapped window with start pulses in RUN, DRAIN and DONE. ED 1,3,0,5.
    push(3'd3, 32'd9, 32'd9, 17'd5);
    cyc(1'b1, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b1, 16'h0005, 16'h0005, 17'h00009);
    cyc(1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 17'h1ABCD);
    cyc(1'b0, 1'b0, 16'h1357, 16'h2468, 17'h00000);
    chk("gap_ready", in_ready, 1);
    cyc(1'b0, 1'b1, 16'h0100, 16'h0100, 17'h00203);
    cyc(1'b0, 1'b1, 16'h0007, 16'h0008, 17'h0000F);
    cyc(1'b1, 1'b0, 16'hFFFF, 16'h0000, 17'h00000);
    chk("gap_busy", busy, 1);
    cyc(1'b0, 1'b1, 16'h8000, 16'h8000, 17'h0FFFB);
    cyc(1'b1, 1'b1, 16'hAAAA, 16'h5555, 17'h00000);
    chk("bp_drain_ready", in_ready, 0);
    chk("bp_drain_done", done, 0);
    cyc(1'b1, 1'b1, 16'hAAAA, 16'h5555, 17'h00000);
    chk("bp_done_pulse", done, 1);
    chk("bp_done_ready", in_ready, 0);
    cyc(1'b0, 1'b1, 16'hAAAA, 16'h5555, 17'h00000);
    chk("bp_start_ignored", busy, 0);

    // Hold: valid traffic with no start must not disturb the result.
    for (int i = 0; i < 10; i++) begin
      chk("hold_ready", in_ready, 0);
      chk("hold_stat_valid", stat_valid, 1);
      chk("hold_err_count", err_count, 3);
      chk("hold_sum_ed", sum_ed, 9);
      chk("hold_max_ed", max_ed, 5);
      cyc(1'b0, 1'b1, 16'h0F0F, 16'hF0F0, 17'h00001);
    end
    cyc(1'b1, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, '0, '0, '0);
    chk("restart_stat_valid", stat_valid, 0);
    chk("restart_busy", busy, 1);
    chk("restart_err_count", err_count, 0);
    chk("restart_sum_ed", sum_ed, 0);

    repeat (3) cyc(1'b0, 1'b0, '0, '0, '0);
    chk("sb32_drained", q32.size(), 0);
    chk("sb8_drained", q8.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
